// File: rtl/arb_conv_bcd_pkg.sv
// Purpose: shared widths, BCD constants and FSM encoding for the BCD conversion scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package arb_conv_bcd_pkg;

    // Binary operand width: covers 0..127, enough for any RTC field.
    localparam int W_BIN = 7;

    // Packed BCD result width: tens nibble [7:4], units nibble [3:0].
    localparam int W_BCD = 8;

    // Result reported for operands that do not fit in two BCD digits.
    localparam logic [W_BCD-1:0] BCD_ERR = 8'hFF;

    // Largest operand with a valid two-digit BCD representation.
    localparam logic [W_BIN-1:0] BCD_MAX = 7'd99;

    // Scheduler states; IDLE is the only state in which a new grant is made.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CONVERT = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/arb_conv_bcd_conv.sv
// Purpose: combinational 7-bit binary to 2-digit packed BCD converter with range flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module arb_conv_bcd_conv
    import arb_conv_bcd_pkg::*;
(
    input  logic [W_BIN-1:0] bin,
    output logic [W_BCD-1:0] bcd,
    output logic             err
);

    logic [3:0] tens;
    logic [3:0] units;

    // Split into decimal digits; out-of-range operands collapse to the error code.
    always_comb begin
        tens  = 4'(bin / 7'd10);
        units = 4'(bin % 7'd10);
        err   = (bin > BCD_MAX);
        if (err) begin
            bcd = BCD_ERR;
        end else begin
            bcd = {tens, units};
        end
    end

endmodule

// File: rtl/arb_conv_bcd.sv
// Purpose: round-robin scheduler sharing one binary-to-BCD converter among N_REQ requesters.
// Latency: grant on the edge that samples req, ack during RESP three edges later; 4 cycles per transaction.
// Backpressure: requesters hold level req until ack; ocupado marks the converter as busy.
module arb_conv_bcd
    import arb_conv_bcd_pkg::*;
#(
    parameter int N_REQ = 4
)
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [W_BIN*N_REQ-1:0] dato_bin,
    output logic [N_REQ-1:0]       ack,
    output logic [W_BCD-1:0]       dato_bcd,
    output logic                   error,
    output logic                   ocupado
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    rr_idx;
    logic [IW-1:0]    ptr_nxt;
    logic [W_BIN-1:0] operand;
    logic [W_BIN-1:0] sel_bin;
    logic [W_BCD-1:0] conv_bcd;
    logic             conv_err;
    logic             ld_grant;
    logic             ld_operand;
    logic             ld_result;
    logic             adv_ptr;

    // Round-robin pick: first set request at or after p, wrapping modulo N_REQ.
    // Scanning offsets from the farthest down to zero lets the nearest hit win.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    p);
        logic [IW-1:0] pick;
        int            j;
        pick = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (r[j]) begin
                pick = IW'(j);
            end
        end
        return pick;
    endfunction

    assign rr_idx  = rr_pick(req, ptr);
    assign ptr_nxt = (grant == LAST_IDX) ? '0 : grant + 1'b1;
    assign sel_bin = dato_bin[int'(grant)*W_BIN +: W_BIN];

    // Single shared converter, fed only from the captured operand so that
    // late changes on dato_bin cannot disturb a transaction in flight.
    arb_conv_bcd_conv u_conv (
        .bin (operand),
        .bcd (conv_bcd),
        .err (conv_err)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state load strobes for the datapath.
    always_comb begin
        state_nxt  = state;
        ld_grant   = 1'b0;
        ld_operand = 1'b0;
        ld_result  = 1'b0;
        adv_ptr    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    ld_grant  = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                ld_operand = 1'b1;
                state_nxt  = CONVERT;
            end
            CONVERT: begin
                ld_result = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                adv_ptr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant index and round-robin pointer; the pointer moves past the
    // serviced requester only once its response has been delivered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant <= '0;
            ptr   <= '0;
        end else begin
            if (ld_grant) begin
                grant <= rr_idx;
            end
            if (adv_ptr) begin
                ptr <= ptr_nxt;
            end
        end
    end

    // Operand capture: sampled exactly once per transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand <= '0;
        end else if (ld_operand) begin
            operand <= sel_bin;
        end
    end

    // Result registers hold their value between conversions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dato_bcd <= '0;
            error    <= 1'b0;
        end else if (ld_result) begin
            dato_bcd <= conv_bcd;
            error    <= conv_err;
        end
    end

    // Ack decodes straight from registered state, so it is one-hot or zero
    // and drops immediately when reset is asserted.
    always_comb begin
        ack = '0;
        if (state == RESP) begin
            ack[grant] = 1'b1;
        end
    end

    assign ocupado = (state != IDLE);

endmodule

// File: tb/tb_arb_conv_bcd.sv
// Purpose: self-checking bench for arb_conv_bcd using an expected-result queue.
// Latency: checks 4 sampled cycles from req drive to ack.
// Backpressure: bench requesters hold req until ack, then drop it on the ack-ending edge.
module tb_arb_conv_bcd;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [7*N-1:0] dato_bin;
    logic [N-1:0]   ack;
    logic [7:0]     dato_bcd;
    logic           error;
    logic           ocupado;

    typedef struct {
        int         idx;
        logic [7:0] bcd;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc;
    int   busy;
    int   ack_cnt;

    always #5 clk = ~clk;

    arb_conv_bcd #(.N_REQ(N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .dato_bin (dato_bin),
        .ack      (ack),
        .dato_bcd (dato_bcd),
        .error    (error),
        .ocupado  (ocupado)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] bcd, input logic err);
        exp_t e;
        e.idx = idx;
        e.bcd = bcd;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next ack, compare it against the queue head, then drop the
    // acked req on the edge that ends the ack cycle (unless kept high).
    task automatic wait_ack(input string tag, input logic [N-1:0] keep,
                            output int cycles, output int busy_cycles);
        logic [N-1:0] a;
        bit           got;
        exp_t         e;
        cycles      = 0;
        busy_cycles = 0;
        got         = 1'b0;
        a           = '0;
        while (!got && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (ocupado) busy_cycles++;
            if (ack != '0) begin
                got = 1'b1;
                a   = ack;
                check_val({tag, "_onehot"}, 32'($onehot(a)), 32'd1);
                if (sb.size() == 0) begin
                    check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_val({tag, "_ack"}, 32'(a), 32'(1 << e.idx));
                    check_val({tag, "_bcd"}, 32'(dato_bcd), 32'(e.bcd));
                    check_val({tag, "_err"}, 32'(error), 32'(e.err));
                end
                @(posedge clk);
                #1;
                req = req & ~(a & ~keep);
            end
        end
        if (!got) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [6:0] bv[4];
        logic [7:0] be[4];
        logic       ee[4];
        logic [6:0] ops[4];
        logic [7:0] res[4];

        bv  = '{7'd0, 7'd99, 7'd100, 7'd127};
        be  = '{8'h00, 8'h99, 8'hFF, 8'hFF};
        ee  = '{1'b0, 1'b0, 1'b1, 1'b1};
        ops = '{7'd12, 7'd34, 7'd56, 7'd78};
        res = '{8'h12, 8'h34, 8'h56, 8'h78};

        reset_n  = 1'b0;
        req      = '0;
        dato_bin = '0;
        #12;
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_bcd", 32'(dato_bcd), 32'd0);
        check_val("rst_err", 32'(error), 32'd0);
        check_val("rst_busy", 32'(ocupado), 32'd0);
        tick();
        reset_n = 1'b1;

        // Single request on requester 0.
        tick();
        dato_bin[6:0] = 7'd45;
        req[0]        = 1'b1;
        push(0, 8'h45, 1'b0);
        wait_ack("single", '0, cyc, busy);
        check_val("single_lat", 32'(cyc), 32'd4);
        check_val("single_busy", 32'(busy), 32'd3);
        @(negedge clk);
        check_val("single_idle", 32'(ocupado), 32'd0);
        check_val("single_hold", 32'(dato_bcd), 32'h45);

        // Range boundaries on requester 1.
        for (int i = 0; i < 4; i++) begin
            tick();
            dato_bin[13:7] = bv[i];
            req[1]         = 1'b1;
            push(1, be[i], ee[i]);
            wait_ack("bnd", '0, cyc, busy);
            check_val("bnd_lat", 32'(cyc), 32'd4);
        end

        // All requesters at once right after reset: strict 0,1,2,3 order.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            dato_bin[7*i +: 7] = ops[i];
            push(i, res[i], 1'b0);
        end
        req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_ack("all", '0, cyc, busy);
            check_val("all_spacing", 32'(cyc), 32'd4);
        end

        // Fairness: req[0] held, req[2] re-raised after each of its acks.
        pulse_reset();
        dato_bin[6:0]   = 7'd5;
        dato_bin[20:14] = 7'd63;
        req             = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            push(0, 8'h05, 1'b0);
            wait_ack("fair0", 4'b0001, cyc, busy);
            check_val("fair0_lat", 32'(cyc), 32'd4);
            push(2, 8'h63, 1'b0);
            wait_ack("fair2", 4'b0001, cyc, busy);
            check_val("fair2_lat", 32'(cyc), 32'd4);
            if (k < 2) req[2] = 1'b1;
            else       req[0] = 1'b0;
        end
        @(negedge clk);
        check_val("fair_idle", 32'(ocupado), 32'd0);

        // Reset asserted while requester 3 is in CONVERT.
        dato_bin[27:21] = 7'd42;
        req[3]          = 1'b1;
        tick();
        tick();
        check_val("mid_busy", 32'(ocupado), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("mid_bcd", 32'(dato_bcd), 32'd0);
        check_val("mid_busy0", 32'(ocupado), 32'd0);
        check_val("mid_ack", 32'(ack), 32'd0);
        tick();
        tick();
        check_val("mid_ack_hold", 32'(ack), 32'd0);
        reset_n = 1'b1;
        push(3, 8'h42, 1'b0);
        wait_ack("retry", '0, cyc, busy);
        check_val("retry_lat", 32'(cyc), 32'd4);

        // Operand changed and req dropped after capture: original operand wins,
        // ack still pulses exactly once.
        tick();
        dato_bin[13:7] = 7'd20;
        req[1]         = 1'b1;
        push(1, 8'h20, 1'b0);
        tick();
        tick();
        dato_bin[13:7] = 7'd88;
        req[1]         = 1'b0;
        wait_ack("late", '0, cyc, busy);
        check_val("late_lat", 32'(cyc), 32'd2);
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack != '0) ack_cnt++;
        end
        check_val("late_no_reack", 32'(ack_cnt), 32'd0);
        check_val("late_hold", 32'(dato_bcd), 32'h20);
        check_val("sb_left", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
